// File: rtl/sparhixcel_pkg.sv
// Shared definitions for the SparhixCel output path: SA controller state encodings,
// the output BRAM writer FSM state type and the bank-count helper.
package sparhixcel_pkg;

   localparam logic [3:0] SA_IDLE    = 4'd0;
   localparam logic [3:0] SA_COMPUTE = 4'd1;
   localparam logic [3:0] SA_FLUSH   = 4'd2;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_COLLECT,
      WR_DRAIN,
      WR_WAIT_READY
   } writer_state_t;

   // One bank per group of N_COLS_ARRAY filters, rounded up.
   function automatic int n_banks(input int filters, input int cols);
      return (filters + cols - 1) / cols;
   endfunction

endpackage

// File: rtl/output_lane_relu.sv
// Single-lane ReLU clamp: negative signed values become zero, others pass through.
module output_lane_relu #(
   parameter int DATA_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0] value,
   output logic [DATA_WIDTH-1:0] clamped
);

   assign clamped = value[DATA_WIDTH-1] ? '0 : value;

endmodule

// File: rtl/output_bram_writer.sv
// Collects systolic-array result vectors into the output BRAM banks and hands full or flushed
// banks to output_ctrl. Build option: OUTPUT_RELU_EN clamps negative lanes to zero on the write path.
module output_bram_writer
   import sparhixcel_pkg::*;
#(
   parameter int NUMBER_SUPPORTED_FILTERS = 30,
   parameter int N_COLS_ARRAY             = 16,
   parameter int DATA_WIDTH               = 16,
   parameter int BRAM_ADDR_WIDTH          = 11,
   localparam int N_BANKS = n_banks(NUMBER_SUPPORTED_FILTERS, N_COLS_ARRAY),
   localparam int GROUP_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
   localparam int NG_W    = $clog2(N_BANKS + 1),
   localparam int VEC_W   = N_COLS_ARRAY * DATA_WIDTH
) (
   input  logic                       clk_i,
   input  logic                       general_rst_i,
   input  logic [3:0]                 sa_state_i,
   input  logic [NG_W-1:0]            num_groups_i,
   input  logic                       sa_valid_i,
   input  logic [GROUP_W-1:0]         sa_group_i,
   input  logic [VEC_W-1:0]           sa_data_i,
   output logic                       sa_ready_o,
   output logic [0:N_BANKS-1]         bram_wr_en_a_o,
   output logic [BRAM_ADDR_WIDTH-1:0] bram_wr_address_a_o,
   output logic [VEC_W-1:0]           bram_wr_data_a_o,
   output logic                       order_empty_bram_o,
   output logic [BRAM_ADDR_WIDTH:0]   fill_count_o,
   input  logic                       bram_ready_i,
   output logic                       group_err_o
);

   writer_state_t              state, state_next;
   logic [BRAM_ADDR_WIDTH-1:0] wr_addr;
   logic [BRAM_ADDR_WIDTH:0]   fill_count, fill_calc;
   logic [NG_W-1:0]            num_groups_q, group_ext;
   logic [VEC_W-1:0]           lane_data;
   logic full, partial, flush_pending, flush_drain, pipe_valid, group_err;
   logic accept, bad_group, last_group, enter_collect;

`ifdef OUTPUT_RELU_EN
   for (genvar i = 0; i < N_COLS_ARRAY; i++) begin : g_relu
      output_lane_relu #(.DATA_WIDTH(DATA_WIDTH)) u_relu (
         .value  (sa_data_i[i*DATA_WIDTH +: DATA_WIDTH]),
         .clamped(lane_data[i*DATA_WIDTH +: DATA_WIDTH])
      );
   end
`else
   assign lane_data = sa_data_i;
`endif

   assign group_ext  = NG_W'(sa_group_i);
   assign bad_group  = group_ext >= num_groups_q;
   assign last_group = group_ext == (num_groups_q - NG_W'(1));
   assign sa_ready_o = (state == WR_COLLECT) && !full && !flush_pending;
   assign accept     = sa_valid_i && sa_ready_o;
   // A half-written row still occupies one word in the banks that did receive data.
   assign fill_calc  = full ? {1'b1, {BRAM_ADDR_WIDTH{1'b0}}}
                            : ({1'b0, wr_addr} + {{BRAM_ADDR_WIDTH{1'b0}}, partial});
   assign enter_collect      = (state != WR_COLLECT) && (state_next == WR_COLLECT);
   assign order_empty_bram_o = (state == WR_DRAIN);
   assign fill_count_o       = fill_count;
   assign group_err_o        = group_err;

   always_ff @(posedge clk_i) begin
      if (general_rst_i) state <= WR_IDLE;
      else               state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         WR_IDLE:       if (sa_state_i == SA_COMPUTE) state_next = WR_COLLECT;
         // Drain only once the last accepted beat has left the write register.
         WR_COLLECT:    if ((full || flush_pending) && !pipe_valid)
                           state_next = (fill_calc == '0) ? WR_IDLE : WR_DRAIN;
         WR_DRAIN:      state_next = WR_WAIT_READY;
         WR_WAIT_READY: if (bram_ready_i) state_next = flush_drain ? WR_IDLE : WR_COLLECT;
         default:       state_next = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (general_rst_i) begin
         wr_addr       <= '0;
         full          <= 1'b0;
         partial       <= 1'b0;
         flush_pending <= 1'b0;
         flush_drain   <= 1'b0;
         num_groups_q  <= '0;
         fill_count    <= '0;
         group_err     <= 1'b0;
      end else begin
         if (state == WR_IDLE && state_next == WR_COLLECT) num_groups_q <= num_groups_i;
         if (enter_collect) begin
            wr_addr       <= '0;
            full          <= 1'b0;
            partial       <= 1'b0;
            flush_pending <= 1'b0;
         end else if (state == WR_COLLECT) begin
            if (sa_state_i == SA_FLUSH) flush_pending <= 1'b1;
            if (accept && bad_group) group_err <= 1'b1;
            if (accept && !bad_group) begin
               if (last_group) begin
                  partial <= 1'b0;
                  if (wr_addr == {BRAM_ADDR_WIDTH{1'b1}}) full <= 1'b1;
                  else                                   wr_addr <= wr_addr + 1'b1;
               end else begin
                  partial <= 1'b1;
               end
            end
         end
         if (state == WR_COLLECT && state_next == WR_DRAIN) begin
            fill_count  <= fill_calc;
            flush_drain <= flush_pending;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (general_rst_i) begin
         pipe_valid          <= 1'b0;
         bram_wr_en_a_o      <= '0;
         bram_wr_address_a_o <= '0;
         bram_wr_data_a_o    <= '0;
      end else begin
         pipe_valid     <= accept;
         bram_wr_en_a_o <= '0;
         if (accept) begin
            for (int b = 0; b < N_BANKS; b++)
               if (!bad_group && group_ext == NG_W'(b)) bram_wr_en_a_o[b] <= 1'b1;
            bram_wr_address_a_o <= wr_addr;
            bram_wr_data_a_o    <= lane_data;
         end
      end
   end

endmodule

// File: tb/tb_output_bram_writer.sv
// Self-checking bench for output_bram_writer with 8-deep banks; honours OUTPUT_RELU_EN when defined.
module tb_output_bram_writer;
   import sparhixcel_pkg::*;

   localparam int BAW = 3;
   localparam int NC  = 16;
   localparam int DW  = 16;
   localparam int NB  = 2;
   localparam int VW  = NC * DW;
   localparam int EW  = 1 + BAW + VW;
`ifdef OUTPUT_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   typedef struct {
      logic        g;
      logic [15:0] l0, l1, e0, e1;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [3:0]     sa_state;
   logic [1:0]     num_groups;
   logic           sa_valid;
   logic           sa_group;
   logic [VW-1:0]  sa_data;
   logic           sa_ready;
   logic [0:NB-1]  wr_en;
   logic [BAW-1:0] wr_addr;
   logic [VW-1:0]  wr_data;
   logic           order_empty;
   logic [BAW:0]   fill_count;
   logic           bram_ready;
   logic           group_err;

   int             checks = 0;
   int             errors = 0;
   int             drain_cnt = 0;
   int             m_addr = 0;
   int             m_ng = 2;
   logic [EW-1:0]  exp_q[$];
   vec_t           tbl[16];

   output_bram_writer #(.BRAM_ADDR_WIDTH(BAW)) dut (
      .clk_i              (clk),
      .general_rst_i      (rst),
      .sa_state_i         (sa_state),
      .num_groups_i       (num_groups),
      .sa_valid_i         (sa_valid),
      .sa_group_i         (sa_group),
      .sa_data_i          (sa_data),
      .sa_ready_o         (sa_ready),
      .bram_wr_en_a_o     (wr_en),
      .bram_wr_address_a_o(wr_addr),
      .bram_wr_data_a_o   (wr_data),
      .order_empty_bram_o (order_empty),
      .fill_count_o       (fill_count),
      .bram_ready_i       (bram_ready),
      .group_err_o        (group_err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [VW-1:0] pack(input logic [15:0] a, input logic [15:0] b);
      logic [VW-1:0] v;
      for (int k = 0; k < NC; k++) v[k*DW +: DW] = (k % 2 == 0) ? a : b;
      return v;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int k = 0; k < NC; k++) v[k*DW +: DW] = 16'($urandom_range(0, 65535));
      return v;
   endfunction

   function automatic logic [VW-1:0] relu_model(input logic [VW-1:0] d);
      logic [VW-1:0] v;
      v = d;
      if (RELU)
         for (int k = 0; k < NC; k++) if (d[k*DW + DW-1]) v[k*DW +: DW] = '0;
      return v;
   endfunction

   function automatic vec_t mk(input logic g, input logic [15:0] l0, input logic [15:0] l1,
                               input logic [15:0] r0, input logic [15:0] r1);
      vec_t t;
      t.g = g; t.l0 = l0; t.l1 = l1;
      t.e0 = RELU ? r0 : l0;
      t.e1 = RELU ? r1 : l1;
      return t;
   endfunction

   // Scoreboard side: every write seen on port A must match the oldest expectation.
   always @(negedge clk) begin
      logic          bank;
      logic [EW-1:0] e;
      if (order_empty) drain_cnt++;
      if (wr_en != '0) begin
         bank = wr_en[1];
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected actual bank=%0d addr=%0d required=none", bank, wr_addr);
         end else begin
            e = exp_q.pop_front();
            if ({bank, wr_addr, wr_data} !== e || $countones(wr_en) != 1) begin
               errors++;
               $display("FAIL write actual en=%b addr=%0d data=%h required bank=%0d addr=%0d data=%h",
                        wr_en, wr_addr, wr_data, e[EW-1], e[VW +: BAW], e[VW-1:0]);
            end
         end
      end
   end

   task automatic send(input logic g, input logic [VW-1:0] d, input logic [VW-1:0] ed, input bit flush);
      bit rdy;
      int n;
      @(posedge clk); #1;
      sa_valid = 1'b1; sa_group = g; sa_data = d;
      if (flush) sa_state = SA_FLUSH;
      rdy = 1'b0; n = 0;
      while (!rdy && n < 100) begin
         @(negedge clk);
         rdy = sa_ready;
         @(posedge clk);
         n++;
      end
      #1;
      sa_valid = 1'b0;
      if (flush) sa_state = SA_IDLE;
      if (!rdy) begin
         checks++; errors++;
         $display("FAIL send_timeout actual=no_accept required=accept");
      end else if (int'(g) < m_ng) begin
         exp_q.push_back({g, BAW'(m_addr), ed});
         if (int'(g) == m_ng - 1) m_addr = (m_addr + 1) % (1 << BAW);
      end
   endtask

   task automatic send_rand(input logic g, input bit flush);
      logic [VW-1:0] d;
      d = rand_vec();
      send(g, d, relu_model(d), flush);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk); #1;
      rst = 1'b1; sa_valid = 1'b0; sa_state = SA_IDLE; bram_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_ready"}, 64'(sa_ready), 64'd0);
      chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
      chk({tag, "_addr"}, 64'(wr_addr), 64'd0);
      chk({tag, "_data"}, 64'(|wr_data), 64'd0);
      chk({tag, "_drain"}, 64'(order_empty), 64'd0);
      chk({tag, "_fill"}, 64'(fill_count), 64'd0);
      chk({tag, "_gerr"}, 64'(group_err), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_addr = 0;
   endtask

   task automatic wait_drain(input string tag, input int fill);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         seen = order_empty;
      end
      chk({tag, "_pulse"}, 64'(seen), 64'd1);
      chk({tag, "_fill"}, 64'(fill_count), 64'(fill));
      @(negedge clk);
      chk({tag, "_pulse_end"}, 64'(order_empty), 64'd0);
   endtask

   initial begin
      int d0;
      rst = 1'b1; sa_state = SA_IDLE; num_groups = 2'd2; sa_valid = 1'b0;
      sa_group = 1'b0; sa_data = '0; bram_ready = 1'b0;

      tbl[0] = mk(1'b0, 16'h8001, 16'h7FFF, 16'h0000, 16'h7FFF);
      tbl[1] = mk(1'b1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
      tbl[2] = mk(1'b0, 16'h1234, 16'hABCD, 16'h1234, 16'h0000);
      tbl[3] = mk(1'b1, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000);
      for (int i = 4; i < 16; i++)
         tbl[i] = mk(1'(i % 2), 16'(16'h0100 + i), 16'(16'hF000 + i), 16'(16'h0100 + i), 16'h0000);

      do_reset("rst0");

      // Three vectors then reset in the middle of collection.
      sa_state = SA_COMPUTE; num_groups = 2'd2; m_ng = 2;
      send_rand(1'b0, 1'b0);
      send_rand(1'b1, 1'b0);
      send_rand(1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("t1_q_empty", 64'(exp_q.size()), 64'd0);
      do_reset("t1");

      // Fill both 8-deep banks from the table; the 17th vector must stall.
      sa_state = SA_COMPUTE;
      d0 = drain_cnt;
      for (int i = 0; i < 16; i++)
         send(tbl[i].g, pack(tbl[i].l0, tbl[i].l1), pack(tbl[i].e0, tbl[i].e1), 1'b0);
      sa_valid = 1'b1; sa_group = 1'b0; sa_data = pack(16'h0042, 16'h0043);
      @(negedge clk);
      chk("t2_stall", 64'(sa_ready), 64'd0);
      wait_drain("t2", 8);
      chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

      // Hold in WAIT_READY, then release; next write restarts at bank 0 addr 0.
      repeat (5) begin
         @(negedge clk);
         chk("t3_hold_ready", 64'(sa_ready), 64'd0);
         chk("t3_hold_fill", 64'(fill_count), 64'd8);
      end
      chk("t3_one_drain", 64'(drain_cnt - d0), 64'd1);
      sa_valid = 1'b0;
      @(posedge clk); #1 bram_ready = 1'b1;
      @(posedge clk); #1 bram_ready = 1'b0;
      m_addr = 0;
      send(1'b0, pack(16'h0042, 16'h0043), pack(16'h0042, 16'h0043), 1'b0);
      repeat (3) @(negedge clk);
      chk("t3_q_empty", 64'(exp_q.size()), 64'd0);

      // Flush arriving with the 5th vector: partial row, fill 3, then back to IDLE.
      do_reset("t4");
      sa_state = SA_COMPUTE; m_ng = 2;
      for (int i = 0; i < 5; i++) send_rand(1'(i % 2), i == 4);
      wait_drain("t4", 3);
      chk("t4_q_empty", 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 bram_ready = 1'b1;
      @(posedge clk); #1 bram_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("t4_idle", 64'(sa_ready), 64'd0);
      sa_state = SA_COMPUTE;
      repeat (3) @(negedge clk);
      chk("t4_recollect", 64'(sa_ready), 64'd1);
      d0 = drain_cnt;
      @(posedge clk); #1 sa_state = SA_FLUSH;
      @(posedge clk); #1 sa_state = SA_IDLE;
      repeat (5) @(negedge clk);
      chk("t4_empty_no_drain", 64'(drain_cnt - d0), 64'd0);
      chk("t4_empty_idle", 64'(sa_ready), 64'd0);

      // Out-of-range group with a single group configured.
      do_reset("t5");
      num_groups = 2'd1; m_ng = 1; sa_state = SA_COMPUTE;
      send_rand(1'b1, 1'b0);
      repeat (2) @(negedge clk);
      chk("t5_gerr", 64'(group_err), 64'd1);
      send_rand(1'b0, 1'b0);
      send_rand(1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("t5_gerr_sticky", 64'(group_err), 64'd1);
      chk("t5_q_empty", 64'(exp_q.size()), 64'd0);
      do_reset("t5_clr");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
